// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int REG_W_DEF = 5;

    // Register index that never produces a hazard (hard-wired zero).
    localparam int REG_ZERO = 0;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             id_branch_i;
    logic             branch_taken_i;
    logic             ex_mem_read_i;
    logic             ex_reg_write_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             mem_mem_read_i;
    logic [REG_W-1:0] mem_rd_i;
    logic             mem_req_i;
    logic             mem_ready_i;

    logic             pc_write_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             freeze_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Pipeline side: drives stage status, consumes controls.
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, id_branch_i, branch_taken_i,
               ex_mem_read_i, ex_reg_write_i, ex_rd_i, mem_mem_read_i, mem_rd_i,
               mem_req_i, mem_ready_i,
        input  pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, freeze_o,
               stall_cnt_o, flush_cnt_o
    );

    // Controller side.
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, id_branch_i, branch_taken_i,
               ex_mem_read_i, ex_reg_write_i, ex_rd_i, mem_mem_read_i, mem_rd_i,
               mem_req_i, mem_ready_i,
        output pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, freeze_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use and
// branch-operand stalls, taken-branch flush, data-memory wait freeze, and
// saturating stall/flush performance counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal issue; hazard/branch rules apply
// ST_MEM_WAIT | data-memory access outstanding; whole pipeline frozen
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_hazard_ctrl_if.slave bus
);
    state_e state_q;
    state_e state_d;

    logic luh;
    logic bh;
    logic hz;

    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic freeze;
    logic apply_run;

    logic stall_en;
    logic flush_en;

    // Index zero is hard-wired, so it can never carry a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] r, input logic [REG_W-1:0] d);
        return (r == d) && (d != REG_W'(REG_ZERO));
    endfunction

    // Source-operand vs. destination hazard detection for the ID instruction.
    always_comb begin
        logic ex_src_match;
        logic mem_src_match;
        ex_src_match  = reg_match(bus.id_rs_i, bus.ex_rd_i) ||
                        (bus.id_uses_rt_i && reg_match(bus.id_rt_i, bus.ex_rd_i));
        mem_src_match = reg_match(bus.id_rs_i, bus.mem_rd_i) ||
                        (bus.id_uses_rt_i && reg_match(bus.id_rt_i, bus.mem_rd_i));
        luh = bus.ex_mem_read_i && ex_src_match;
        // The branch compares in ID, so it also waits on ALU results still in
        // EX and on load data still in MEM.
        bh  = bus.id_branch_i &&
              ((bus.ex_reg_write_i && ex_src_match) ||
               (bus.mem_mem_read_i && mem_src_match));
        hz  = luh || bh;
    end

    // Next state and combinational control outputs.
    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        freeze       = 1'b0;
        apply_run    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.mem_req_i && !bus.mem_ready_i) begin
                    freeze  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    apply_run = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.mem_ready_i) begin
                    freeze = 1'b1;
                end else begin
                    // Release cycle behaves like a normal RUN cycle.
                    apply_run = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (apply_run) begin
            if (hz) begin
                // Branch outcome is ignored; it re-evaluates once operands arrive.
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (bus.id_branch_i && bus.branch_taken_i) begin
                pc_write    = 1'b1;
                if_id_flush = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end

        // Reset holds the front end flushed and injects NOPs.
        if (rst_i) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            freeze       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.if_id_stall_o  = if_id_stall;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_bubble_o = id_ex_bubble;
    assign bus.freeze_o       = freeze;

    assign stall_en = freeze || if_id_stall;
    assign flush_en = if_id_flush && !rst_i;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_en),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (flush_en),
        .cnt_o (bus.flush_cnt_o)
    );
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Generates the IF/ID stall and flush controls, PC write enable, ID/EX bubble and whole-pipeline freeze.
- Covers load-use hazards, ID-stage branch operand hazards, taken-branch flush and multi-cycle data-memory waits.
- Also keeps saturating stall and flush performance counters; sits beside the hazard/forwarding logic in ID.

Parameters:
- CNT_W, 16, width of each performance counter.
- REG_W, 5, register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_rs_i  in  REG_W  rs of instruction in ID.
- id_rt_i  in  REG_W  rt of instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- id_branch_i  in  1  ID instruction is a branch (beq).
- branch_taken_i  in  1  ID-stage branch compare result.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_reg_write_i  in  1  EX instruction writes a register.
- ex_rd_i  in  REG_W  EX destination.
- mem_mem_read_i  in  1  MEM instruction is a load.
- mem_rd_i  in  REG_W  MEM destination.
- mem_req_i  in  1  MEM stage issuing a data-memory access this cycle.
- mem_ready_i  in  1  data memory completes access this cycle.
- pc_write_o  out  1  PC may update.
- if_id_stall_o  out  1  IF/ID holds its contents.
- if_id_flush_o  out  1  IF/ID loads zero.
- id_ex_bubble_o  out  1  ID/EX loads a NOP (controls zeroed).
- freeze_o  out  1  all pipeline registers and PC hold.
- stall_cnt_o  out  CNT_W  cycles with hazard stall or freeze.
- flush_cnt_o  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is asynchronous and active-high.
- Reset state: state=RUN; stall_cnt_o=0; flush_cnt_o=0.
- Outputs while rst_i=1: pc_write_o=0, if_id_stall_o=0, if_id_flush_o=1, id_ex_bubble_o=1, freeze_o=0.
- Match rule: register index 0 never matches. For register r, match(r, d) = (r == d) and (d != 0). The rt term applies only when id_uses_rt_i=1.
- Load-use hazard (luh): ex_mem_read_i=1 and match(id_rs/id_rt, ex_rd_i).
- Branch operand hazards (bh), evaluated only when id_branch_i=1:
  - ex_reg_write_i=1 and match on ex_rd_i;
  - or mem_mem_read_i=1 and match on mem_rd_i.
- hz = luh or bh.
- FSM states: RUN and MEM_WAIT.
- RUN, priority from highest:
  1. mem_req_i=1 and mem_ready_i=0: freeze_o=1, pc_write_o=0, all other outputs 0; next state MEM_WAIT.
  2. hz=1: pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1, if_id_flush_o=0. branch_taken_i is ignored; the branch re-evaluates once operands are ready.
  3. id_branch_i=1 and branch_taken_i=1: pc_write_o=1 (target), if_id_flush_o=1, if_id_stall_o=0.
  4. Otherwise: pc_write_o=1, all other outputs 0.
- MEM_WAIT:
  - freeze_o=1 and pc_write_o=0 until mem_ready_i=1.
  - In the cycle mem_ready_i=1: freeze_o=0, RUN rules 2–4 apply to the current inputs, next state RUN.
  - Branch, hazard and mem_req_i inputs are ignored while frozen, apart from the release cycle.
- Latency:
  - All control outputs are combinational from state and inputs, giving same-cycle effect.
  - State and counters update on the rising edge.
- Output invariants:
  - if_id_stall_o and if_id_flush_o are never both 1.
  - freeze_o=1 implies if_id_stall_o=0, if_id_flush_o=0 and id_ex_bubble_o=0.
- Counters:
  - stall_cnt_o increments on each cycle with freeze_o or if_id_stall_o asserted.
  - flush_cnt_o increments on each cycle with if_id_flush_o asserted while rst_i=0.
  - Both counters saturate at all-ones with no wrap.
- Reset mid-MEM_WAIT: immediate return to RUN and counters clear. The pending memory access is abandoned; memory is reset by the same rst_i.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding constants ST_RUN and ST_MEM_WAIT;
  - REG_ZERO constant;
  - CNT_W default.
- One natural sub-module: sat_counter (CNT_W-wide, enable, async active-high reset, saturates), instantiated twice.

Test Plan:
1. Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs_i=5 -> exactly 1 cycle of pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1; stall_cnt_o=1.
2. Register zero: ex_mem_read_i=1, ex_rd_i=0, id_rs_i=0 -> no stall, pc_write_o=1.
3. Branch after load:
   - Setup: id_branch_i=1, id_rs_i=3; cycle 1 has load to r3 in EX, cycle 2 has it in MEM; branch_taken_i=1 throughout.
   - Required: 2 stall cycles, then 1 flush cycle (if_id_flush_o=1); flush_cnt_o=1, stall_cnt_o=2.
4. Memory wait:
   - Setup: mem_req_i=1, mem_ready_i=0 for 3 cycles, then mem_ready_i=1.
   - Required: freeze_o=1 for 3 cycles, 0 in the release cycle; state returns to RUN; stall_cnt_o=3.
   - branch_taken_i pulsed during the freeze -> no flush.
5. Async reset: assert rst_i mid-MEM_WAIT between clock edges -> state RUN and counters 0 immediately; if_id_flush_o=1 and id_ex_bubble_o=1 while rst_i=1.
6. Saturation: CNT_W=4, hold a hazard for 20 cycles -> stall_cnt_o stops at 15.
